// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage: FSM state encoding,
// datapath width, the opcodes used to build instruction words, and the reset PC.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_STALL = 2'd2,
    FETCH_HALT  = 2'd3
  } fetch_state_t;

  // Sign-extended branch immediate, already scaled from words to bytes.
  function automatic logic [WORD_W-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC computation: sequential, branch and jump targets and
// the jump > branch > sequential priority mux. No state lives here.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] branch_addr;
  logic [WORD_W-1:0] jump_addr;

  always_comb begin
    pc_plus4    = pc + 32'd4;
    branch_addr = pc_plus4 + branch_offset(branch_imm);
    // Jumps stay inside the 256 MB region of the delay-slot address.
    jump_addr   = {pc_plus4[31:28], jump_target, 2'b00};
    next_pc     = pc_plus4;
    if (jump) begin
      next_pc = jump_addr;
    end else if (branch_taken) begin
      next_pc = branch_addr;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and retired-fetch counter feeding instruction memory.
// Define FETCH_COUNT_EN to build the fetch_count register; otherwise it reads 0.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               branch_taken,
  input  logic [15:0]        branch_imm,
  input  logic               jump,
  input  logic [25:0]        jump_target,
  output logic [WORD_W-1:0]  imem_address,
  input  logic [WORD_W-1:0]  imem_instruction,
  output logic [WORD_W-1:0]  instruction,
  output logic [WORD_W-1:0]  pc,
  output logic [WORD_W-1:0]  pc_plus4,
  output logic               valid,
  output logic               halted,
  output logic               fault,
  output logic [WORD_W-1:0]  fetch_count,
  output fetch_state_t       fetch_state
);

  logic [WORD_W-1:0] next_pc;
  logic              out_of_range;
  logic              pc_advance;

  next_pc_sel u_next_pc_sel (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  // 33-bit compare so a PC near 2^32 cannot wrap back into range.
  always_comb begin
    out_of_range = ({1'b0, pc} + 33'd3) >= 33'(IMEM_BYTES);
    pc_advance   = (fetch_state == FETCH_RUN) && !halt_req && !out_of_range && !stall;
    valid        = ((fetch_state == FETCH_RUN) && !out_of_range) || (fetch_state == FETCH_STALL);
    halted       = (fetch_state == FETCH_HALT);
    instruction  = valid ? imem_instruction : '0;
    imem_address = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_state <= FETCH_BOOT;
      pc          <= RESET_PC;
      fault       <= 1'b0;
    end else begin
      case (fetch_state)
        FETCH_BOOT: fetch_state <= FETCH_RUN;
        FETCH_RUN: begin
          if (halt_req) begin
            fetch_state <= FETCH_HALT;
          end else if (out_of_range) begin
            fetch_state <= FETCH_HALT;
            fault       <= 1'b1;
          end else if (stall) begin
            fetch_state <= FETCH_STALL;
          end else begin
            pc <= next_pc;
          end
        end
        FETCH_STALL: begin
          // Control-flow inputs are ignored here; leaving STALL refetches pc.
          if (halt_req) begin
            fetch_state <= FETCH_HALT;
          end else if (!stall) begin
            fetch_state <= FETCH_RUN;
          end
        end
        default: fetch_state <= FETCH_HALT;
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (pc_advance) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a 4 KB instance for the main flow and a
// 16-byte instance for the out-of-range fault path, sharing all inputs.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;

  logic [31:0] addr_a, imem_a, instr_a, pc_a, pc4_a, cnt_a;
  logic        valid_a, halted_a, fault_a;
  fetch_state_t st_a;
  logic [31:0] addr_b, imem_b, instr_b, pc_b, pc4_b, cnt_b;
  logic        valid_b, halted_b, fault_b;
  fetch_state_t st_b;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a[3] ? {OP_J, a[27:2]} : {OP_BEQ, 10'h0, a[15:0]};
  endfunction

  function automatic logic [31:0] fc(input int n);
`ifdef FETCH_COUNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  assign imem_a = mem_word(addr_a);
  assign imem_b = mem_word(addr_b);

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(4096)) u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .jump(jump), .jump_target(jump_target),
    .imem_address(addr_a), .imem_instruction(imem_a), .instruction(instr_a),
    .pc(pc_a), .pc_plus4(pc4_a), .valid(valid_a), .halted(halted_a),
    .fault(fault_a), .fetch_count(cnt_a), .fetch_state(st_a)
  );

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(16)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .jump(jump), .jump_target(jump_target),
    .imem_address(addr_b), .imem_instruction(imem_b), .instruction(instr_b),
    .pc(pc_b), .pc_plus4(pc4_b), .valid(valid_b), .halted(halted_b),
    .fault(fault_b), .fetch_count(cnt_b), .fetch_state(st_b)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [31:0] e_pc, input logic e_valid,
                         input logic [31:0] e_cnt);
    check_vec({tag, ".pc"}, pc_a, e_pc);
    check_vec({tag, ".addr"}, addr_a, e_pc);
    check_vec({tag, ".valid"}, 32'(valid_a), 32'(e_valid));
    check_vec({tag, ".instr"}, instr_a, e_valid ? mem_word(e_pc) : 32'h0);
    check_vec({tag, ".cnt"}, cnt_a, e_cnt);
  endtask

  task automatic check_b(input string tag, input logic [31:0] e_pc, input logic e_valid,
                         input logic e_halted, input logic e_fault, input logic [31:0] e_cnt);
    check_vec({tag, ".b_pc"}, pc_b, e_pc);
    check_vec({tag, ".b_addr"}, addr_b, e_pc);
    check_vec({tag, ".b_valid"}, 32'(valid_b), 32'(e_valid));
    check_vec({tag, ".b_instr"}, instr_b, e_valid ? mem_word(e_pc) : 32'h0);
    check_vec({tag, ".b_halted"}, 32'(halted_b), 32'(e_halted));
    check_vec({tag, ".b_fault"}, 32'(fault_b), 32'(e_fault));
    check_vec({tag, ".b_cnt"}, cnt_b, e_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    stall = 1'b0;
    halt_req = 1'b0;
    branch_taken = 1'b0;
    branch_imm = 16'h0;
    jump = 1'b0;
    jump_target = 26'h0;
  endtask

  initial begin
    // Reset values while rst is held.
    @(negedge clk);
    check_a("reset", 32'h0, 1'b0, 32'h0);
    check_vec("reset.halted", 32'(halted_a), 32'h0);
    check_vec("reset.fault", 32'(fault_a), 32'h0);
    check_vec("reset.pc4", pc4_a, 32'h4);
    check_vec("reset.state", 32'(st_a), 32'(FETCH_BOOT));

    rst = 1'b0;
    #1;
    check_a("boot", 32'h0, 1'b0, 32'h0);
    check_vec("boot.state", 32'(st_a), 32'(FETCH_BOOT));

    // Sequential fetch 0, 4, 8, 12.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      step();
      check_a("seq", exp_q.pop_front(), 1'b1, fc(i));
    end
    check_vec("seq.pc4", pc4_a, 32'd16);
    check_vec("seq.b_valid12", 32'(valid_b), 32'h1);

    // Branches from pc=12: self-loop, forward, backward.
    branch_taken = 1'b1; branch_imm = 16'hFFFF;
    step(); check_a("br_loop", 32'd12, 1'b1, fc(4));
    branch_imm = 16'd5;
    step(); check_a("br_fwd", 32'd36, 1'b1, fc(5));
    branch_imm = 16'hFFFD;
    step(); check_a("br_back", 32'd28, 1'b1, fc(6));

    // Jumps; jump beats a simultaneous branch.
    branch_taken = 1'b0; jump = 1'b1; jump_target = 26'd3;
    step(); check_a("jump", 32'd12, 1'b1, fc(7));
    branch_taken = 1'b1; branch_imm = 16'd5; jump_target = 26'd10;
    step(); check_a("jump_prio", 32'd40, 1'b1, fc(8));
    branch_taken = 1'b0; jump_target = 26'd2;
    step(); check_a("jump8", 32'd8, 1'b1, fc(9));

    // Stall three cycles at pc=8 with control-flow inputs that must be ignored.
    clear_ctrl();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_a("stall", 32'd8, 1'b1, fc(9));
      check_vec("stall.state", 32'(st_a), 32'(FETCH_STALL));
      branch_taken = 1'b1; branch_imm = 16'd7; jump = 1'b1; jump_target = 26'd20;
    end
    clear_ctrl();
    step(); check_a("unstall", 32'd8, 1'b1, fc(9));
    check_vec("unstall.state", 32'(st_a), 32'(FETCH_RUN));
    step(); check_a("post_stall", 32'd12, 1'b1, fc(10));

    // Asynchronous reset in the middle of a stall.
    stall = 1'b1;
    step(); check_vec("arst.pre_state", 32'(st_a), 32'(FETCH_STALL));
    #1 rst = 1'b1;
    #1;
    check_a("arst", 32'h0, 1'b0, 32'h0);
    check_vec("arst.state", 32'(st_a), 32'(FETCH_BOOT));
    check_vec("arst.halted", 32'(halted_a), 32'h0);
    clear_ctrl();
    @(negedge clk);
    rst = 1'b0;
    step(); check_a("restart", 32'h0, 1'b1, fc(0));
    step(); check_a("restart4", 32'h4, 1'b1, fc(1));

    // Halt request at pc=4: clean halt, then all inputs ignored.
    halt_req = 1'b1;
    step();
    check_a("halt", 32'h4, 1'b0, fc(1));
    check_vec("halt.halted", 32'(halted_a), 32'h1);
    check_vec("halt.fault", 32'(fault_a), 32'h0);
    check_b("halt", 32'h4, 1'b0, 1'b1, 1'b0, fc(1));
    halt_req = 1'b0; stall = 1'b1; jump = 1'b1; jump_target = 26'd9;
    step();
    check_b("halt_hold", 32'h4, 1'b0, 1'b1, 1'b0, fc(1));
    clear_ctrl();

    // Out-of-range fetch on the 16-byte instance.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_b("oor_edge", 32'd16, 1'b0, 1'b0, 1'b0, fc(4));
    check_a("oor_big", 32'd16, 1'b1, fc(4));
    step();
    check_b("fault", 32'd16, 1'b0, 1'b1, 1'b1, fc(4));
    check_vec("fault.state", 32'(st_b), 32'(FETCH_HALT));
    step();
    check_b("fault_hold", 32'd16, 1'b0, 1'b1, 1'b1, fc(4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
